// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the text-mode renderer.
// Side-band bundle carried alongside the character/font memory reads.
package vga_pkg;

  localparam int HVA = 640;
  localparam int HFP = 16;
  localparam int HSP = 96;
  localparam int HBP = 48;
  localparam int HWL = 800;

  localparam int VVA = 480;
  localparam int VFP = 10;
  localparam int VSP = 2;
  localparam int VBP = 33;
  localparam int VWF = 525;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  typedef logic [11:0] rgb_t;

  typedef struct packed {
    logic       visible;
    logic       cur_hit;
    logic [2:0] pix_x;
    logic [3:0] pix_y;
    logic       hs;
    logic       vs;
  } sband_t;

  localparam sband_t SB_RST = '{visible: 1'b0, cur_hit: 1'b0, pix_x: 3'd0,
                                pix_y: 4'd0, hs: 1'b1, vs: 1'b1};

  // row*80+col from shifts; row<=32, col<=99 keeps the sum below 4096
  function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col);
    return {row, 6'b0} + {2'b0, row, 4'b0} + {5'b0, col};
  endfunction

endpackage

// File: rtl/vga_text_render_if.sv
// Signal bundle between the timing/memory side and the text renderer.
// master = timing source + memories + config, slave = renderer.
interface vga_text_render_if;
  logic        en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync_i;
  logic        vsync_i;
  logic [11:0] char_addr;
  logic [7:0]  char_data;
  logic [11:0] font_addr;
  logic [7:0]  font_data;
  logic [11:0] fg_color;
  logic [11:0] bg_color;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        cursor_en;
  logic        hsync;
  logic        vsync;
  logic [3:0]  R;
  logic [3:0]  G;
  logic [3:0]  B;

  modport master (
    output en, hcount, vcount, hsync_i, vsync_i, char_data, font_data,
           fg_color, bg_color, cursor_col, cursor_row, cursor_en,
    input  char_addr, font_addr, hsync, vsync, R, G, B
  );

  modport slave (
    input  en, hcount, vcount, hsync_i, vsync_i, char_data, font_data,
           fg_color, bg_color, cursor_col, cursor_row, cursor_en,
    output char_addr, font_addr, hsync, vsync, R, G, B
  );
endinterface

// File: rtl/vga_delay_line.sv
// Enabled shift register with a reset value; every stage is exposed as a tap.
// o_q[0] is the first registered stage, o_q[DEPTH-1] the last.
module vga_delay_line #(
  parameter int             W       = 1,
  parameter int             DEPTH   = 1,
  parameter logic [W-1:0]   RST_VAL = '0
)(
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      i_en,
  input  logic [W-1:0]              i_d,
  output logic [DEPTH-1:0][W-1:0]   o_q
);

  logic [DEPTH-1:0][W-1:0] r_q;
  logic [DEPTH-1:0][W-1:0] w_in;

  assign w_in[0] = i_d;
  for (genvar s = 1; s < DEPTH; s++) begin : g_chain
    assign w_in[s] = r_q[s-1];
  end

  always_ff @(posedge clk) begin
    if (!resetn)   r_q <= {DEPTH{RST_VAL}};
    else if (i_en) r_q <= w_in;
  end

  assign o_q = r_q;

endmodule

// File: rtl/vga_text_render.sv
// Text-mode renderer: char RAM read -> font ROM read -> pixel select, with a
// blinking cursor overlay and syncs delayed to stay aligned with colour.
module vga_text_render
  import vga_pkg::*;
#(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int BLINK_LOG2 = 5
)(
  input  logic               clk,
  input  logic               resetn,
  vga_text_render_if.slave   bus
);

  localparam int SBW = $bits(sband_t);

  logic [6:0]            w_col;
  logic [5:0]            w_row;
  sband_t                w_sb0;
  sband_t                w_s1;
  sband_t                w_s2;
  logic [1:0][SBW-1:0]   w_taps;
  logic                  w_bit;
  logic                  w_blink;
  logic                  w_on;
  rgb_t                  w_rgb;
  logic                  w_vs_fall;

  logic [11:0]           r_char_addr;
  logic [11:0]           r_font_addr;
  rgb_t                  r_rgb;
  logic                  r_hsync;
  logic                  r_vsync;
  logic                  r_vs_prev;
  logic [BLINK_LOG2:0]   r_blink_cnt;

  // S1 side-band: derived from the raw counters in the same en cycle
  assign w_col = bus.hcount[9:3];
  assign w_row = bus.vcount[9:4];

  always_comb begin
    w_sb0         = SB_RST;
    w_sb0.visible = (bus.hcount < 10'(COLS * CHAR_W)) && (bus.vcount < 10'(ROWS * CHAR_H));
    w_sb0.cur_hit = (w_col == bus.cursor_col) && (w_row == {1'b0, bus.cursor_row});
    w_sb0.pix_x   = bus.hcount[2:0];
    w_sb0.pix_y   = bus.vcount[3:0];
    w_sb0.hs      = bus.hsync_i;
    w_sb0.vs      = bus.vsync_i;
  end

  vga_delay_line #(
    .W       (SBW),
    .DEPTH   (2),
    .RST_VAL (SB_RST)
  ) u_sband (
    .clk    (clk),
    .resetn (resetn),
    .i_en   (bus.en),
    .i_d    (w_sb0),
    .o_q    (w_taps)
  );

  assign w_s1 = w_taps[0];
  assign w_s2 = w_taps[1];

  // S1 address, S2 address: memories answer one clk later, before the next en
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_char_addr <= '0;
      r_font_addr <= '0;
    end else if (bus.en) begin
      r_char_addr <= cell_addr(w_row, w_col);
      r_font_addr <= {bus.char_data, w_s1.pix_y};
    end
  end

  // S3 pixel select; blink reads the counter before any same-cycle increment
  assign w_bit   = bus.font_data[3'd7 - w_s2.pix_x];
  assign w_blink = r_blink_cnt[BLINK_LOG2];
  assign w_on    = w_bit ^ (w_s2.cur_hit & bus.cursor_en & w_blink);
  assign w_rgb   = w_s2.visible ? (w_on ? bus.fg_color : bus.bg_color) : rgb_t'(0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (bus.en) begin
      r_rgb   <= w_rgb;
      r_hsync <= w_s2.hs;
      r_vsync <= w_s2.vs;
    end
  end

  assign w_vs_fall = r_vs_prev & ~bus.vsync_i;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_vs_prev   <= 1'b1;
      r_blink_cnt <= '0;
    end else if (bus.en) begin
      r_vs_prev <= bus.vsync_i;
      if (w_vs_fall) r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign bus.char_addr = r_char_addr;
  assign bus.font_addr = r_font_addr;
  assign bus.R         = r_rgb[11:8];
  assign bus.G         = r_rgb[7:4];
  assign bus.B         = r_rgb[3:0];
  assign bus.hsync     = r_hsync;
  assign bus.vsync     = r_vsync;

endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render: reset, addressing, glyph pixels,
// visibility boundaries, sync delay, cursor blink and mid-line reset.
module tb_vga_text_render;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  vga_text_render_if bus();

  vga_text_render #(.COLS(80), .ROWS(30), .BLINK_LOG2(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [7:0] cmem [4096];
  logic [7:0] fmem [4096];

  always @(posedge clk) begin
    bus.char_data <= cmem[bus.char_addr];
    bus.font_data <= fmem[bus.font_addr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rgb_o();
    return {20'b0, bus.R, bus.G, bus.B};
  endfunction

  // one pixel: en high for one clk, low for the next so memories settle
  task automatic pix(input int h, input int v, input logic hs, input logic vs);
    bus.hcount  = 10'(h);
    bus.vcount  = 10'(v);
    bus.hsync_i = hs;
    bus.vsync_i = vs;
    bus.en      = 1'b1;
    @(posedge clk); #1;
    bus.en      = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic px(input int h, input int v);
    pix(h, v, 1'b1, 1'b1);
  endtask

  task automatic probe(input int h, input int v);
    repeat (3) px(h, v);
  endtask

  task automatic vs_edge();
    pix(0, 490, 1'b1, 1'b0);
    pix(0, 490, 1'b1, 1'b1);
  endtask

  initial begin
    logic [11:0] glyph_exp [8];
    int first_low;
    int lows;

    checks = 0;
    errors = 0;
    for (int a = 0; a < 4096; a++) begin
      cmem[a] = 8'h00;
      fmem[a] = 8'h00;
    end
    cmem[162]  = 8'hA5; fmem[12'hA53] = 8'h40;
    cmem[0]    = 8'h41; fmem[12'h410] = 8'h81;
    cmem[79]   = 8'h42; fmem[12'h420] = 8'h01;
    cmem[2320] = 8'h43; fmem[12'h43F] = 8'h80;
    cmem[165]  = 8'h44; fmem[12'h440] = 8'hF0;

    resetn         = 1'b0;
    bus.en         = 1'b0;
    bus.hcount     = 10'd17;
    bus.vcount     = 10'd35;
    bus.hsync_i    = 1'b1;
    bus.vsync_i    = 1'b1;
    bus.fg_color   = 12'h00F;
    bus.bg_color   = 12'hFF0;
    bus.cursor_col = 7'd5;
    bus.cursor_row = 5'd2;
    bus.cursor_en  = 1'b0;

    // reset held 4 clk with en toggling
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.en = ~bus.en;
    end
    chk("rst_char_addr", 32'(bus.char_addr), 32'd0);
    chk("rst_font_addr", 32'(bus.font_addr), 32'd0);
    chk("rst_rgb", rgb_o(), 32'h000);
    chk("rst_hsync", 32'(bus.hsync), 32'd1);
    chk("rst_vsync", 32'(bus.vsync), 32'd1);
    bus.en = 1'b0;
    resetn = 1'b1;

    // address path and three-en latency after release
    px(17, 35);
    chk("char_addr_162", 32'(bus.char_addr), 32'd162);
    chk("rel_rgb_1", rgb_o(), 32'h000);
    chk("rel_hsync_1", 32'(bus.hsync), 32'd1);
    px(17, 35);
    chk("font_addr_A53", 32'(bus.font_addr), 32'hA53);
    chk("rel_rgb_2", rgb_o(), 32'h000);
    px(17, 35);
    chk("rel_rgb_3", rgb_o(), 32'h00F);

    // glyph 1000_0001 across hcount 0..7
    glyph_exp = '{12'h00F, 12'hFF0, 12'hFF0, 12'hFF0, 12'hFF0, 12'hFF0, 12'hFF0, 12'h00F};
    for (int h = 0; h < 10; h++) begin
      px(h, 0);
      if (h >= 2) chk($sformatf("glyph_px%0d", h - 2), rgb_o(), 32'(glyph_exp[h-2]));
    end

    // visibility boundaries
    px(639, 0);
    px(640, 0);
    px(0, 479);
    chk("h639_visible", rgb_o(), 32'h00F);
    px(0, 480);
    chk("h640_black", rgb_o(), 32'h000);
    px(0, 480);
    chk("v479_visible", rgb_o(), 32'h00F);
    px(0, 480);
    chk("v480_black", rgb_o(), 32'h000);

    // hsync pulse at 704..799 shows up 3 en later, 96 long
    first_low = -1;
    lows = 0;
    for (int i = 0; i < 106; i++) begin
      int h;
      h = (i < 100) ? 700 + i : i - 100;
      pix(h, 0, (h >= 704) ? 1'b0 : 1'b1, 1'b1);
      if (bus.hsync === 1'b0) begin
        if (first_low < 0) first_low = i;
        lows++;
      end
    end
    chk("hsync_first_low", 32'(first_low), 32'd6);
    chk("hsync_low_len", 32'(lows), 32'd96);

    // cursor blink at (5,2)
    bus.cursor_en = 1'b1;
    probe(40, 32);
    chk("cur_f0_px0", rgb_o(), 32'h00F);
    probe(44, 32);
    chk("cur_f0_px4", rgb_o(), 32'hFF0);
    repeat (31) vs_edge();
    probe(40, 32);
    chk("cur_f31_px0", rgb_o(), 32'h00F);
    // 32nd falling edge coincides with the cursor pixel reaching S3
    px(40, 32);
    px(40, 32);
    pix(0, 490, 1'b1, 1'b0);
    chk("cur_edge_preinc", rgb_o(), 32'h00F);
    px(0, 490);
    probe(40, 32);
    chk("cur_f32_px0", rgb_o(), 32'hFF0);
    probe(44, 32);
    chk("cur_f32_px4", rgb_o(), 32'h00F);
    probe(48, 32);
    chk("cur_f32_neighbour", rgb_o(), 32'hFF0);
    bus.cursor_en = 1'b0;
    probe(40, 32);
    chk("cur_disabled", rgb_o(), 32'h00F);

    // one-clk reset mid-line clears blink and flushes the pipe
    bus.cursor_en = 1'b1;
    px(40, 32);
    resetn = 1'b0;
    bus.en = 1'b1;
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.en = 1'b0;
    chk("mid_rst_rgb", rgb_o(), 32'h000);
    chk("mid_rst_hsync", 32'(bus.hsync), 32'd1);
    chk("mid_rst_char_addr", 32'(bus.char_addr), 32'd0);
    px(40, 32);
    chk("mid_rel_rgb_1", rgb_o(), 32'h000);
    px(40, 32);
    chk("mid_rel_rgb_2", rgb_o(), 32'h000);
    px(40, 32);
    chk("mid_rel_blink_cleared", rgb_o(), 32'h00F);
    chk("mid_rel_vsync", 32'(bus.vsync), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
